// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, d = x - y, LSB first, one bit per
//   clock. A single full-subtractor cell and a borrow flop replace a ripple
//   chain. The operation is started and finished through a start/busy/done
//   handshake.
//
//   state | meaning
//   IDLE  | waiting for i_start; operands captured when it is seen
//   RUN   | one difference bit produced per clock, WIDTH clocks in total
//   DONE  | results just updated; o_done high for this single cycle
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    asynchronous, active-high reset
//   i_start  request, only looked at in IDLE
//   i_x      minuend, captured on an accepted start
//   i_y      subtrahend, captured on an accepted start
//   o_busy   high while in RUN
//   o_done   one-cycle pulse when the result registers have been updated
//   o_d      x - y mod 2^WIDTH, held until the next completion
//   o_bo     borrow out, 1 iff x < y unsigned
//   o_ovf    signed overflow of the subtraction
//   o_zero   1 iff o_d == 0
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_d,
   output logic             o_bo,
   output logic             o_ovf,
   output logic             o_zero
);

   localparam int              CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   // Only WIDTH-1 partial bits need storing; the bit being produced this
   // cycle completes the word combinationally on the last edge.
   logic [WIDTH-2:0] r_res;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic             r_xmsb;
   logic             r_ymsb;

   logic [WIDTH-1:0] r_d;
   logic             r_bo;
   logic             r_ovf;
   logic             r_zero;

   logic             w_busy;
   logic             w_done;
   logic             w_last;
   logic             w_diff;
   logic             w_br_nxt;
   logic [WIDTH-1:0] w_res_shift;
   logic             w_ovf;

   assign w_last      = (r_cnt == LAST);
   assign w_diff      = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_nxt    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_res_shift = {w_diff, r_res};
   // On the last edge w_diff is the result MSB.
   assign w_ovf       = (r_xmsb != r_ymsb) && (w_diff != r_xmsb);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_RUN:   w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
         r_xmsb <= 1'b0;
         r_ymsb <= 1'b0;
         r_d    <= '0;
         r_bo   <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_a    <= i_x;
                  r_b    <= i_y;
                  r_br   <= 1'b0;
                  r_cnt  <= '0;
                  r_xmsb <= i_x[WIDTH-1];
                  r_ymsb <= i_y[WIDTH-1];
               end
            end
            S_RUN: begin
               r_a   <= {1'b0, r_a[WIDTH-1:1]};
               r_b   <= {1'b0, r_b[WIDTH-1:1]};
               r_br  <= w_br_nxt;
               r_res <= w_res_shift[WIDTH-1:1];
               if (w_last) begin
                  r_cnt  <= '0;
                  r_d    <= w_res_shift;
                  r_bo   <= w_br_nxt;
                  r_ovf  <= w_ovf;
                  r_zero <= (w_res_shift == '0);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy = w_busy;
   assign o_done = w_done;
   assign o_d    = r_d;
   assign o_bo   = r_bo;
   assign o_ovf  = r_ovf;
   assign o_zero = r_zero;

endmodule
